intersection_phase_scheduler: RTL and testbench
===============================================

// Module: intersection_phase_scheduler
// PURPOSE
// Demand-driven phase scheduler for the four-way intersection light sequencer.
// - Latches vehicle, left-turn and pedestrian requests.
// - Chooses the next phase and its duration, and hands it to the sequencer over a valid/ready handshake.
// - Inserts all-red clearance on every axis change.
// - Handles emergency-vehicle preemption by aborting the running phase.
// PARAMETERS
// T_ALL_RED    4   all-red clearance time (cycles)
// T_BOTH       10  NS_BOTH/EW_BOTH green time
// T_DOUBLE     5   single-approach double green time (N/S/E/W_DOUBLE)
// T_LEFT       5   NS/EW_DOUBLE_LEFT time
// T_PED_EXT    6   added to T_BOTH when the phase serves a pedestrian request
// T_PREEMPT    8   preemption phase time, re-issued while preempt held
// PORTS
// clk            in   1   clock
// reset          in   1   synchronous, active-high reset
// det_thru       in   4   through detectors {W,E,S,N}, level
// det_left       in   4   left-turn detectors {W,E,S,N}, level
// ped_ns, ped_ew in   1   crosswalk buttons, level or pulse
// preempt_valid  in   1   emergency preemption request, level
// preempt_dir    in   2   0=N 1=S 2=E 3=W; sampled while preempt_valid
// phase_ready    in   1   sequencer accepts phase
// phase_done     in   1   one-cycle pulse, sequencer finished accepted phase
// phase_valid    out  1   phase offer valid
// phase_id       out  4   0 NS_BOTH,1 N_DBL,2 S_DBL,3 EW_BOTH,4 E_DBL,5 W_DBL,6 NS_LEFT,7 EW_LEFT,8 ALL_RED
// phase_time     out  8   duration in cycles for phase_id
// seq_abort      out  1   one-cycle pulse: sequencer must drop the current phase
// walk_ns, walk_ew out 1  pedestrian WALK indication
// preempt_active out  1   high from preemption entry until release
// BEHAVIOUR
// - Reset outputs:
//   - phase_valid=0, phase_id=8, phase_time=0, seq_abort=0, walk_*=0, preempt_active=0.
//   - All pending bits=0, last_axis=EW (so NS is considered first).
// - Request latch: pend_* bits set one cycle after the input is high.
//   - Served bits clear on handshake acceptance (phase_valid && phase_ready).
//   - If set and clear coincide, set wins.
// - Handshake:
//   - phase_id and phase_time are held stable while phase_valid && !phase_ready.
//   - phase_valid drops the cycle after acceptance.
//   - phase_done is ignored outside ACTIVE and CLR_ACTIVE.
// - States: IDLE, CLR_ISSUE, CLR_ACTIVE, ISSUE, ACTIVE, PRE_CLR, PRE_HOLD.
//   - IDLE, no pending: stay, phase_valid=0.
//   - IDLE, pending: select (below) into cand; phase_valid rises the next cycle.
//     - cand axis != last_axis -> CLR_ISSUE; otherwise -> ISSUE.
//   - CLR_ISSUE: offer ALL_RED / T_ALL_RED; accepted -> CLR_ACTIVE; phase_done -> ISSUE.
//   - ISSUE: offer cand; accepted -> ACTIVE and last_axis=cand axis; phase_done -> IDLE.
// - Selection: check the axis opposite last_axis first; if it has no pending, use the same axis. Per axis (NS shown):
//   - pend_left N&S -> NS_LEFT.
//   - else left N & thru N -> N_DBL; else left S & thru S -> S_DBL.
//   - else any thru N/S, ped_ns or single left -> NS_BOTH.
//   - NS_BOTH clears thru N, S, ped_ns and left bits. Double phases clear their approach's thru and left.
// - Pedestrian timing:
//   - phase_time = min(T_BOTH + T_PED_EXT, 255) when NS_BOTH/EW_BOTH serves a pending ped bit, else T_BOTH.
//   - walk_ns/walk_ew high from acceptance through the phase_done cycle of that phase.
// - Preemption:
//   - preempt_valid in any state other than PRE_*: seq_abort pulses if a phase is accepted-but-not-done.
//   - Offer is withdrawn (phase_valid may drop without acceptance, only here) -> PRE_CLR.
//   - preempt_active=1 from the same cycle.
//   - PRE_CLR: ALL_RED / T_ALL_RED; done -> PRE_HOLD.
//   - PRE_HOLD: offer NS_BOTH (dir 0/1) or EW_BOTH (dir 2/3) / T_PREEMPT; walk_* forced 0.
//     - On done: re-offer while preempt_valid, else last_axis=preempt axis, preempt_active=0, -> IDLE.
// - Pending bits keep latching during preemption and are never lost.
// - Reset mid-operation returns to the reset values next cycle, regardless of state.
// TESTING
// - Reset, then det_thru=4'b0001 for 1 cycle, ready=1:
//   - ALL_RED/4 offered (axis change from reset EW), then NS_BOTH/10; pend cleared.
// - last_axis=NS, det_left=4'b0100, det_thru=4'b0100:
//   - ALL_RED/4, then E_DBL/5; with ped_ew instead, EW_BOTH/16 with walk_ew high until done.
// - det_left=4'b0011 while EW active:
//   - after done, ALL_RED/4, then NS_LEFT/5; pend_left[1:0]=0.
// - Hold phase_ready=0 for 7 cycles with phase_valid up:
//   - phase_id/phase_time unchanged; accepted on cycle 8.
// - preempt_valid, dir=2, mid NS_BOTH:
//   - seq_abort 1 cycle, ALL_RED/4, EW_BOTH/8 repeated twice while held.
//   - After release, IDLE; a pending NS request gets ALL_RED and then NS_BOTH.
// - Assert reset during CLR_ACTIVE:
//   - next cycle all outputs at reset values, pending cleared.

Source files
------------

// File: rtl/intersection_phase_scheduler_if.sv
// Phase offer handshake between the phase scheduler (master) and the light sequencer (slave).
interface intersection_phase_scheduler_if;
    logic       phase_valid;
    logic       phase_ready;
    logic [3:0] phase_id;
    logic [7:0] phase_time;
    logic       phase_done;
    logic       seq_abort;

    modport master (
        output phase_valid, phase_id, phase_time, seq_abort,
        input  phase_ready, phase_done
    );

    modport slave (
        input  phase_valid, phase_id, phase_time, seq_abort,
        output phase_ready, phase_done
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven four-way intersection phase scheduler: latches requests, picks the next phase,
// inserts all-red clearance on axis changes and handles emergency preemption.
module intersection_phase_scheduler #(
    parameter int unsigned T_ALL_RED = 4,
    parameter int unsigned T_BOTH    = 10,
    parameter int unsigned T_DOUBLE  = 5,
    parameter int unsigned T_LEFT    = 5,
    parameter int unsigned T_PED_EXT = 6,
    parameter int unsigned T_PREEMPT = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [3:0]                            det_thru,
    input  logic [3:0]                            det_left,
    input  logic                                  ped_ns,
    input  logic                                  ped_ew,
    input  logic                                  preempt_valid,
    input  logic [1:0]                            preempt_dir,
    intersection_phase_scheduler_if.master        ph,
    output logic                                  walk_ns,
    output logic                                  walk_ew,
    output logic                                  preempt_active
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CLR_ISSUE  = 3'd1;
    localparam logic [2:0] S_CLR_ACTIVE = 3'd2;
    localparam logic [2:0] S_ISSUE      = 3'd3;
    localparam logic [2:0] S_ACTIVE     = 3'd4;
    localparam logic [2:0] S_PRE_CLR    = 3'd5;
    localparam logic [2:0] S_PRE_HOLD   = 3'd6;

    localparam logic [3:0] ID_NS_BOTH = 4'd0;
    localparam logic [3:0] ID_N_DBL   = 4'd1;
    localparam logic [3:0] ID_S_DBL   = 4'd2;
    localparam logic [3:0] ID_EW_BOTH = 4'd3;
    localparam logic [3:0] ID_E_DBL   = 4'd4;
    localparam logic [3:0] ID_W_DBL   = 4'd5;
    localparam logic [3:0] ID_NS_LEFT = 4'd6;
    localparam logic [3:0] ID_EW_LEFT = 4'd7;
    localparam logic [3:0] ID_ALL_RED = 4'd8;

    localparam int unsigned PED_SUM     = T_BOTH + T_PED_EXT;
    localparam logic [7:0]  TM_ALL_RED  = 8'(T_ALL_RED);
    localparam logic [7:0]  TM_BOTH     = 8'(T_BOTH);
    localparam logic [7:0]  TM_DOUBLE   = 8'(T_DOUBLE);
    localparam logic [7:0]  TM_LEFT     = 8'(T_LEFT);
    localparam logic [7:0]  TM_PREEMPT  = 8'(T_PREEMPT);
    localparam logic [7:0]  TM_BOTH_PED = (PED_SUM > 255) ? 8'd255 : 8'(PED_SUM);

    logic [2:0] state_q, state_d;
    logic       phase_valid_q, phase_valid_d;
    logic [3:0] phase_id_q, phase_id_d;
    logic [7:0] phase_time_q, phase_time_d;
    logic       seq_abort_q, seq_abort_d;
    logic       walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
    logic       preempt_active_q, preempt_active_d;
    logic       last_ew_q, last_ew_d;
    logic [3:0] pend_thru_q, pend_thru_d, pend_left_q, pend_left_d;
    logic [1:0] pend_ped_q, pend_ped_d;
    logic [3:0] cand_id_q, cand_id_d;
    logic [7:0] cand_time_q, cand_time_d;
    logic       cand_ped_q, cand_ped_d, cand_ew_q, cand_ew_d;
    logic       busy_q, busy_d;
    logic       pre_ew_q, pre_ew_d;

    logic        accept, done, served, in_pre, dir_ew;
    logic        ns_pend, ew_pend, sel_ew;
    logic [12:0] sel;
    logic [3:0]  clr_thru, clr_left;
    logic [1:0]  clr_ped;

    // Result packing: {ped_served, time[7:0], id[3:0]}; bit 0 of th/lf is the N (or E) approach.
    function automatic logic [12:0] pick_axis(input logic ew, input logic [1:0] th,
                                              input logic [1:0] lf, input logic pd);
        logic [3:0] id;
        logic [7:0] tm;
        logic       ps;
        ps = 1'b0;
        if (lf[0] && lf[1]) begin
            id = ew ? ID_EW_LEFT : ID_NS_LEFT;
            tm = TM_LEFT;
        end else if (lf[0] && th[0]) begin
            id = ew ? ID_E_DBL : ID_N_DBL;
            tm = TM_DOUBLE;
        end else if (lf[1] && th[1]) begin
            id = ew ? ID_W_DBL : ID_S_DBL;
            tm = TM_DOUBLE;
        end else begin
            id = ew ? ID_EW_BOTH : ID_NS_BOTH;
            ps = pd;
            tm = pd ? TM_BOTH_PED : TM_BOTH;
        end
        return {ps, tm, id};
    endfunction

    assign accept  = phase_valid_q && ph.phase_ready;
    assign done    = ph.phase_done && busy_q;
    assign in_pre  = (state_q == S_PRE_CLR) || (state_q == S_PRE_HOLD);
    assign dir_ew  = (preempt_dir == 2'd2) || (preempt_dir == 2'd3);
    assign ns_pend = (|pend_thru_q[1:0]) || (|pend_left_q[1:0]) || pend_ped_q[0];
    assign ew_pend = (|pend_thru_q[3:2]) || (|pend_left_q[3:2]) || pend_ped_q[1];
    // The axis opposite the last served one wins whenever it has anything pending.
    assign sel_ew  = last_ew_q ? !ns_pend : ew_pend;
    assign sel     = sel_ew ? pick_axis(1'b1, pend_thru_q[3:2], pend_left_q[3:2], pend_ped_q[1])
                            : pick_axis(1'b0, pend_thru_q[1:0], pend_left_q[1:0], pend_ped_q[0]);

    always_comb begin
        state_d          = state_q;
        phase_valid_d    = phase_valid_q;
        phase_id_d       = phase_id_q;
        phase_time_d     = phase_time_q;
        seq_abort_d      = 1'b0;
        walk_ns_d        = walk_ns_q;
        walk_ew_d        = walk_ew_q;
        preempt_active_d = preempt_active_q;
        last_ew_d        = last_ew_q;
        cand_id_d        = cand_id_q;
        cand_time_d      = cand_time_q;
        cand_ped_d       = cand_ped_q;
        cand_ew_d        = cand_ew_q;
        pre_ew_d         = pre_ew_q;
        busy_d           = busy_q;
        served           = 1'b0;
        if (accept) busy_d = 1'b1;
        if (done)   busy_d = 1'b0;

        case (state_q)
            S_IDLE: if (ns_pend || ew_pend) begin
                {cand_ped_d, cand_time_d, cand_id_d} = sel;
                cand_ew_d     = sel_ew;
                phase_valid_d = 1'b1;
                if (sel_ew != last_ew_q) begin
                    state_d      = S_CLR_ISSUE;
                    phase_id_d   = ID_ALL_RED;
                    phase_time_d = TM_ALL_RED;
                end else begin
                    state_d      = S_ISSUE;
                    phase_id_d   = sel[3:0];
                    phase_time_d = sel[11:4];
                end
            end
            S_CLR_ISSUE: if (accept) begin
                phase_valid_d = 1'b0;
                state_d       = S_CLR_ACTIVE;
            end
            S_CLR_ACTIVE: if (done) begin
                state_d       = S_ISSUE;
                phase_valid_d = 1'b1;
                phase_id_d    = cand_id_q;
                phase_time_d  = cand_time_q;
            end
            S_ISSUE: if (accept) begin
                phase_valid_d = 1'b0;
                state_d       = S_ACTIVE;
                last_ew_d     = cand_ew_q;
                served        = 1'b1;
                walk_ns_d     = cand_ped_q && !cand_ew_q;
                walk_ew_d     = cand_ped_q && cand_ew_q;
            end
            S_ACTIVE: if (done) begin
                state_d   = S_IDLE;
                walk_ns_d = 1'b0;
                walk_ew_d = 1'b0;
            end
            S_PRE_CLR: begin
                if (accept) phase_valid_d = 1'b0;
                if (done) begin
                    state_d       = S_PRE_HOLD;
                    phase_valid_d = 1'b1;
                    phase_id_d    = pre_ew_q ? ID_EW_BOTH : ID_NS_BOTH;
                    phase_time_d  = TM_PREEMPT;
                end
            end
            S_PRE_HOLD: begin
                if (accept) phase_valid_d = 1'b0;
                if (done) begin
                    if (preempt_valid) begin
                        phase_valid_d = 1'b1;
                        pre_ew_d      = dir_ew;
                        phase_id_d    = dir_ew ? ID_EW_BOTH : ID_NS_BOTH;
                        phase_time_d  = TM_PREEMPT;
                    end else begin
                        state_d          = S_IDLE;
                        last_ew_d        = pre_ew_q;
                        preempt_active_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Preemption overrides whatever the FSM decided; a coincident acceptance is aborted
        // and its requests stay pending rather than being consumed.
        if (preempt_valid && !in_pre) begin
            seq_abort_d      = busy_q || accept;
            state_d          = S_PRE_CLR;
            phase_valid_d    = 1'b1;
            phase_id_d       = ID_ALL_RED;
            phase_time_d     = TM_ALL_RED;
            preempt_active_d = 1'b1;
            pre_ew_d         = dir_ew;
            busy_d           = 1'b0;
            walk_ns_d        = 1'b0;
            walk_ew_d        = 1'b0;
            last_ew_d        = last_ew_q;
            served           = 1'b0;
        end

        clr_thru = '0;
        clr_left = '0;
        clr_ped  = '0;
        if (served) begin
            case (cand_id_q)
                ID_NS_BOTH: begin clr_thru = 4'b0011; clr_left = 4'b0011; clr_ped = 2'b01; end
                ID_N_DBL:   begin clr_thru = 4'b0001; clr_left = 4'b0001; end
                ID_S_DBL:   begin clr_thru = 4'b0010; clr_left = 4'b0010; end
                ID_EW_BOTH: begin clr_thru = 4'b1100; clr_left = 4'b1100; clr_ped = 2'b10; end
                ID_E_DBL:   begin clr_thru = 4'b0100; clr_left = 4'b0100; end
                ID_W_DBL:   begin clr_thru = 4'b1000; clr_left = 4'b1000; end
                ID_NS_LEFT: clr_left = 4'b0011;
                ID_EW_LEFT: clr_left = 4'b1100;
                default: ;
            endcase
        end
        pend_thru_d = (pend_thru_q & ~clr_thru) | det_thru;
        pend_left_d = (pend_left_q & ~clr_left) | det_left;
        pend_ped_d  = (pend_ped_q & ~clr_ped) | {ped_ew, ped_ns};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            phase_valid_q    <= 1'b0;
            phase_id_q       <= ID_ALL_RED;
            phase_time_q     <= '0;
            seq_abort_q      <= 1'b0;
            walk_ns_q        <= 1'b0;
            walk_ew_q        <= 1'b0;
            preempt_active_q <= 1'b0;
            last_ew_q        <= 1'b1;
            pend_thru_q      <= '0;
            pend_left_q      <= '0;
            pend_ped_q       <= '0;
            cand_id_q        <= ID_ALL_RED;
            cand_time_q      <= '0;
            cand_ped_q       <= 1'b0;
            cand_ew_q        <= 1'b0;
            busy_q           <= 1'b0;
            pre_ew_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            phase_valid_q    <= phase_valid_d;
            phase_id_q       <= phase_id_d;
            phase_time_q     <= phase_time_d;
            seq_abort_q      <= seq_abort_d;
            walk_ns_q        <= walk_ns_d;
            walk_ew_q        <= walk_ew_d;
            preempt_active_q <= preempt_active_d;
            last_ew_q        <= last_ew_d;
            pend_thru_q      <= pend_thru_d;
            pend_left_q      <= pend_left_d;
            pend_ped_q       <= pend_ped_d;
            cand_id_q        <= cand_id_d;
            cand_time_q      <= cand_time_d;
            cand_ped_q       <= cand_ped_d;
            cand_ew_q        <= cand_ew_d;
            busy_q           <= busy_d;
            pre_ew_q         <= pre_ew_d;
        end
    end

    assign ph.phase_valid = phase_valid_q;
    assign ph.phase_id    = phase_id_q;
    assign ph.phase_time  = phase_time_q;
    assign ph.seq_abort   = seq_abort_q;
    assign walk_ns        = walk_ns_q;
    assign walk_ew        = walk_ew_q;
    assign preempt_active = preempt_active_q;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench: acts as the light sequencer and predicts every offer from a request-set model.
module tb_intersection_phase_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] det_thru, det_left;
    logic       ped_ns, ped_ew, preempt_valid;
    logic [1:0] preempt_dir;
    logic       walk_ns, walk_ew, preempt_active;

    intersection_phase_scheduler_if ph();

    intersection_phase_scheduler #(
        .T_ALL_RED(4), .T_BOTH(10), .T_DOUBLE(5), .T_LEFT(5), .T_PED_EXT(6), .T_PREEMPT(8)
    ) dut (
        .clk(clk), .reset(reset), .det_thru(det_thru), .det_left(det_left),
        .ped_ns(ped_ns), .ped_ew(ped_ew), .preempt_valid(preempt_valid), .preempt_dir(preempt_dir),
        .ph(ph), .walk_ns(walk_ns), .walk_ew(walk_ew), .preempt_active(preempt_active)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Outstanding requests per approach (index 0=N 1=S 2=E 3=W) and per crosswalk (0=NS 1=EW).
    bit [3:0] m_thru, m_left;
    bit [1:0] m_ped;
    bit       m_last_ew;

    task automatic model_reset();
        m_thru = '0; m_left = '0; m_ped = '0; m_last_ew = 1'b1;
    endtask

    // Chooses the next phase: the axis across from the last served one if it wants service,
    // otherwise the same axis; then lefts-both, a double, or the combined green.
    task automatic model_pick(output int id, output int tm, output bit ped, output bit ew);
        bit ns_any, ew_any;
        int p, q, base;
        ns_any = m_thru[0] | m_thru[1] | m_left[0] | m_left[1] | m_ped[0];
        ew_any = m_thru[2] | m_thru[3] | m_left[2] | m_left[3] | m_ped[1];
        if (m_last_ew) ew = ns_any ? 1'b0 : 1'b1;
        else           ew = ew_any ? 1'b1 : 1'b0;
        p = ew ? 2 : 0;
        q = p + 1;
        base = ew ? 3 : 0;
        ped = 1'b0;
        if (m_left[p] && m_left[q])      begin id = 6 + int'(ew); tm = 5; end
        else if (m_left[p] && m_thru[p]) begin id = base + 1; tm = 5; end
        else if (m_left[q] && m_thru[q]) begin id = base + 2; tm = 5; end
        else begin
            id = base;
            ped = m_ped[ew];
            tm = ped ? 16 : 10;
        end
    endtask

    task automatic model_serve(input int id, input bit ew);
        int p, base;
        p = ew ? 2 : 0;
        base = ew ? 3 : 0;
        if (id >= 6) begin
            m_left[p] = 0; m_left[p+1] = 0;
        end else if (id == base) begin
            m_thru[p] = 0; m_thru[p+1] = 0; m_left[p] = 0; m_left[p+1] = 0; m_ped[ew] = 0;
        end else begin
            m_thru[p + id - base - 1] = 0;
            m_left[p + id - base - 1] = 0;
        end
        m_last_ew = ew;
    endtask

    task automatic pulse_req(input logic [3:0] th, input logic [3:0] lf, input logic pns, input logic pew);
        det_thru = th; det_left = lf; ped_ns = pns; ped_ew = pew;
        m_thru |= th; m_left |= lf; m_ped |= {pew, pns};
        @(negedge clk);
        det_thru = '0; det_left = '0; ped_ns = 1'b0; ped_ew = 1'b0;
    endtask

    task automatic accept_phase(input int eid, input int etm, input int stall, input bit ewn, input bit eww);
        int n;
        n = 0;
        while (ph.phase_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (ph.phase_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL offer_timeout: phase_valid=%0b required 1 (id %0d)", ph.phase_valid, eid);
        end
        vectors++;
        if (ph.phase_id !== 4'(eid) || ph.phase_time !== 8'(etm)) begin
            miscompares++;
            $display("FAIL offer: id/time=%0d/%0d required %0d/%0d", ph.phase_id, ph.phase_time, eid, etm);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            vectors++;
            if (ph.phase_valid !== 1'b1 || ph.phase_id !== 4'(eid) || ph.phase_time !== 8'(etm)) begin
                miscompares++;
                $display("FAIL hold_stable: valid/id/time=%0b/%0d/%0d required 1/%0d/%0d",
                         ph.phase_valid, ph.phase_id, ph.phase_time, eid, etm);
            end
        end
        ph.phase_ready = 1'b1;
        @(negedge clk);
        ph.phase_ready = 1'b0;
        vectors++;
        if (ph.phase_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_drop: phase_valid=%0b required 0", ph.phase_valid);
        end
        vectors++;
        if ({walk_ns, walk_ew} !== {ewn, eww}) begin
            miscompares++;
            $display("FAIL walk_on: walk_ns/ew=%0b%0b required %0b%0b", walk_ns, walk_ew, ewn, eww);
        end
    endtask

    task automatic finish_phase(input int hold, input bit ewn, input bit eww);
        repeat (hold) @(negedge clk);
        vectors++;
        if ({walk_ns, walk_ew} !== {ewn, eww}) begin
            miscompares++;
            $display("FAIL walk_hold: walk_ns/ew=%0b%0b required %0b%0b", walk_ns, walk_ew, ewn, eww);
        end
        ph.phase_done = 1'b1;
        @(negedge clk);
        ph.phase_done = 1'b0;
        vectors++;
        if ({walk_ns, walk_ew} !== 2'b00) begin
            miscompares++;
            $display("FAIL walk_off: walk_ns/ew=%0b%0b required 00", walk_ns, walk_ew);
        end
    endtask

    // Serves offers until the model has nothing pending; optionally injects requests once,
    // while the first real phase is running.
    task automatic drain(input bit inject, input logic [3:0] ith, input logic [3:0] ilf,
                         input logic [1:0] iped, input int stall);
        int id, tm, guard, st;
        bit ped, ew, inj;
        inj = inject;
        guard = 0;
        while ((m_thru != 0 || m_left != 0 || m_ped != 0) && guard < 12) begin
            model_pick(id, tm, ped, ew);
            if (ew != m_last_ew) begin
                accept_phase(8, 4, $urandom_range(0, 2), 1'b0, 1'b0);
                finish_phase($urandom_range(0, 3), 1'b0, 1'b0);
            end
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            accept_phase(id, tm, st, ped && !ew, ped && ew);
            model_serve(id, ew);
            if (inj) begin
                pulse_req(ith, ilf, iped[0], iped[1]);
                inj = 1'b0;
            end
            finish_phase($urandom_range(1, 4), ped && !ew, ped && ew);
            guard++;
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (ph.phase_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet: phase_valid=%0b required 0", ph.phase_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (ph.phase_valid !== 1'b0 || ph.phase_id !== 4'd8 || ph.phase_time !== 8'd0 ||
            ph.seq_abort !== 1'b0 || walk_ns !== 1'b0 || walk_ew !== 1'b0 || preempt_active !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: valid/id/time/abort/walk/pre=%0b/%0d/%0d/%0b/%0b%0b/%0b required 0/8/0/0/00/0",
                     tag, ph.phase_valid, ph.phase_id, ph.phase_time, ph.seq_abort, walk_ns, walk_ew,
                     preempt_active);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_basic();
        pulse_req(4'b0001, 4'b0000, 1'b0, 1'b0);
        drain(1'b0, '0, '0, '0, -1);
    endtask

    task automatic test_double_and_ped();
        pulse_req(4'b0100, 4'b0100, 1'b0, 1'b0);
        drain(1'b0, '0, '0, '0, -1);
        pulse_req(4'b0001, 4'b0000, 1'b0, 1'b0);
        drain(1'b0, '0, '0, '0, -1);
        pulse_req(4'b0000, 4'b0000, 1'b0, 1'b1);
        drain(1'b0, '0, '0, '0, -1);
    endtask

    task automatic test_left_inject();
        pulse_req(4'b1000, 4'b0000, 1'b0, 1'b0);
        drain(1'b1, 4'b0000, 4'b0011, 2'b00, -1);
    endtask

    task automatic test_back_to_back();
        pulse_req(4'b0010, 4'b0000, 1'b0, 1'b0);
        drain(1'b0, '0, '0, '0, 7);
    endtask

    task automatic test_preempt();
        int id, tm;
        bit ped, ew;
        pulse_req(4'b0001, 4'b0000, 1'b0, 1'b0);
        model_pick(id, tm, ped, ew);
        if (ew != m_last_ew) begin
            accept_phase(8, 4, 0, 1'b0, 1'b0);
            finish_phase(1, 1'b0, 1'b0);
        end
        accept_phase(id, tm, 0, 1'b0, 1'b0);
        model_serve(id, ew);
        @(negedge clk);
        preempt_valid = 1'b1;
        preempt_dir = 2'd2;
        @(negedge clk);
        vectors++;
        if (ph.seq_abort !== 1'b1 || preempt_active !== 1'b1 || ph.phase_valid !== 1'b1 ||
            ph.phase_id !== 4'd8 || ph.phase_time !== 8'd4) begin
            miscompares++;
            $display("FAIL preempt_entry: abort/pre/valid/id/time=%0b/%0b/%0b/%0d/%0d required 1/1/1/8/4",
                     ph.seq_abort, preempt_active, ph.phase_valid, ph.phase_id, ph.phase_time);
        end
        pulse_req(4'b0010, 4'b0000, 1'b0, 1'b0);
        vectors++;
        if (ph.seq_abort !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pulse: seq_abort=%0b required 0", ph.seq_abort);
        end
        accept_phase(8, 4, 1, 1'b0, 1'b0);
        finish_phase(2, 1'b0, 1'b0);
        accept_phase(3, 8, 0, 1'b0, 1'b0);
        finish_phase(2, 1'b0, 1'b0);
        accept_phase(3, 8, 2, 1'b0, 1'b0);
        vectors++;
        if (preempt_active !== 1'b1) begin
            miscompares++;
            $display("FAIL preempt_held: preempt_active=%0b required 1", preempt_active);
        end
        preempt_valid = 1'b0;
        finish_phase(2, 1'b0, 1'b0);
        vectors++;
        if (preempt_active !== 1'b0) begin
            miscompares++;
            $display("FAIL preempt_release: preempt_active=%0b required 0", preempt_active);
        end
        m_last_ew = 1'b1;
        drain(1'b0, '0, '0, '0, -1);
    endtask

    task automatic test_reset_mid();
        pulse_req(4'b0100, 4'b0000, 1'b0, 1'b0);
        accept_phase(8, 4, 0, 1'b0, 1'b0);
        pulse_req(4'b0000, 4'b0000, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        vectors++;
        if (ph.phase_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pending_cleared: phase_valid=%0b required 0", ph.phase_valid);
        end
        pulse_req(4'b0001, 4'b0000, 1'b0, 1'b0);
        drain(1'b0, '0, '0, '0, -1);
    endtask

    task automatic test_random();
        logic [3:0] th, lf, ith, ilf;
        logic [1:0] pd, ipd;
        for (int it = 0; it < 10; it++) begin
            th = 4'($urandom_range(0, 15));
            lf = 4'($urandom_range(0, 15));
            pd = 2'($urandom_range(0, 3));
            if (th == 0 && lf == 0 && pd == 0) th = 4'b0100;
            ith = 4'($urandom_range(0, 15));
            ilf = 4'($urandom_range(0, 15));
            ipd = 2'($urandom_range(0, 3));
            pulse_req(th, lf, pd[0], pd[1]);
            drain(1'($urandom_range(0, 1)), ith, ilf, ipd, -1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        det_thru = '0; det_left = '0; ped_ns = 1'b0; ped_ew = 1'b0;
        preempt_valid = 1'b0; preempt_dir = 2'd0;
        ph.phase_ready = 1'b0; ph.phase_done = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_double_and_ped();
        test_left_inject();
        test_back_to_back();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
